mc_control_fsm: RTL and testbench

Multi-cycle control sequencer for the CPU datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, using the same opcode map as the single-cycle decoder. Each state drives the register-file, ALU-mux, PC and memory strobes for that step. It sits between the instruction register and the shared single-port memory, and stalls on a ready/request memory handshake.

---
 rtl/mc_control_fsm.sv | 163 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on unknown opcodes.
// Optional cycle/retire counters are enabled with `define MC_CTRL_PERF_EN.
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_ctl,
  output logic        ext_op,
  output logic        illegal_op,
  output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q;
  logic   retire_d;

  logic is_r, is_is, is_il, is_lw, is_sw, is_j, is_beq, is_bne, is_legal;

  always_comb begin
    is_r     = (op == 6'b000000);
    is_is    = (op == 6'b010110) || (op == 6'b010111) || (op == 6'b111111);
    is_il    = (op == 6'b011000) || (op == 6'b011001) || (op == 6'b011011);
    is_lw    = (op == 6'b100100);
    is_sw    = (op == 6'b100101);
    is_j     = (op == 6'b100011);
    is_beq   = (op == 6'b100000);
    is_bne   = (op == 6'b100001);
    is_legal = is_r | is_is | is_il | is_lw | is_sw | is_j | is_beq | is_bne;
  end

  // Strobes are gated by rst_n so nothing fires while reset is asserted.
  always_comb begin
    state_d    = state_q;
    retire_d   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctl    = 2'd0;
    ext_op     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          ext_op    = 1'b1;
          state_d   = is_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (is_r) begin
            alu_src_a = 1'b1;
            alu_ctl   = 2'd2;
            state_d   = S_WB;
          end else if (is_is || is_il) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_ctl   = 2'd3;
            ext_op    = is_is;
            state_d   = S_WB;
          end else if (is_lw || is_sw) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            ext_op    = 1'b1;
            state_d   = S_MEM;
          end else if (is_beq || is_bne) begin
            alu_src_a = 1'b1;
            alu_ctl   = 2'd1;
            pc_src    = 2'd1;
            pc_we     = (is_beq & zero) | (is_bne & ~zero);
            retire_d  = 1'b1;
          end else if (is_j) begin
            pc_we     = 1'b1;
            pc_src    = 2'd2;
            retire_d  = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
          if (mem_ready) begin
            state_d  = is_lw ? S_WB : S_FETCH;
            retire_d = is_sw;
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          reg_dst    = is_r;
          mem_to_reg = is_lw;
          retire_d   = 1'b1;
          state_d    = S_FETCH;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state      = rst_n ? state_q : 3'd0;
  assign illegal_op = rst_n & illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
`ifdef MC_CTRL_PERF_EN
      cycle_cnt  <= 32'd0;
      retire_cnt <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
`ifdef MC_CTRL_PERF_EN
      if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire_d)          retire_cnt <= retire_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm; each cycle's strobes are compared to hand-built expected words.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       rq, we, io, irw, pcw;
    logic [1:0] pcs;
    logic       rgw, rdst, m2r, asa;
    logic [1:0] asb, alc;
    logic       ext, ill;
  } ctl_t;

  function automatic ctl_t mk(input logic [2:0] st, input logic rq, we, io, irw, pcw,
                              input logic [1:0] pcs, input logic rgw, rdst, m2r, asa,
                              input logic [1:0] asb, alc, input logic ext, ill);
    mk = {st, rq, we, io, irw, pcw, pcs, rgw, rdst, m2r, asa, asb, alc, ext, ill};
  endfunction

  //                               st req we io irw pcw pcs rgw dst m2r asa asb alc ext ill
  localparam ctl_t ZERO    = mk(3'd0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t F_WAIT  = mk(3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0);
  localparam ctl_t F_GO    = mk(3'd0, 1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0);
  localparam ctl_t DEC     = mk(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd3, 2'd0, 1, 0);
  localparam ctl_t EX_R    = mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0);
  localparam ctl_t EX_LS   = mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 2'd0, 1, 0);
  localparam ctl_t EX_BRT  = mk(3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0);
  localparam ctl_t EX_BRN  = mk(3'd2, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0);
  localparam ctl_t EX_J    = mk(3'd2, 0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t EX_ANDI = mk(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 2'd3, 0, 0);
  localparam ctl_t MEM_LW  = mk(3'd3, 1, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t MEM_SW  = mk(3'd3, 1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t WB_R    = mk(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t WB_I    = mk(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t WB_LW   = mk(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0);
  localparam ctl_t TRAP    = mk(3'd7, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1);

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] op;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic       ext_op, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_ctl;
  logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
  int exp_cyc = 0;
  int exp_ret = 0;
  bit in_trap = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .ext_op(ext_op),
    .illegal_op(illegal_op), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  ctl_t obs;
  assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_ctl, ext_op, illegal_op};

  task automatic chk(input string tag, input ctl_t exp);
    #1;
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs settle and are compared 1-2 time units after the edge.
  task automatic step();
    @(posedge clk);
`ifdef MC_CTRL_PERF_EN
    if (rst_n && !in_trap) exp_cyc++;
`endif
    #1;
  endtask

  task automatic retire();
`ifdef MC_CTRL_PERF_EN
    exp_ret++;
`endif
  endtask

  task automatic chk_perf(input string tag);
`ifdef MC_CTRL_PERF_EN
    total++;
    assert (cycle_cnt === 32'(exp_cyc) && retire_cnt === 32'(exp_ret)) begin
      passed++;
    end else begin
      $error("FAIL %s: observed cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
             tag, cycle_cnt, retire_cnt, exp_cyc, exp_ret);
    end
`else
    if (tag.len() == 0) $display("perf counters not built");
`endif
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b000000;
    chk("reset_pre", ZERO);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", ZERO);
    end

    // add, zero-wait: released straight into its fetch
    rst_n = 1'b1;
    chk("add_fetch", F_GO);       step();
    chk("add_decode", DEC);       step();
    chk("add_exec", EX_R);        step();
    chk("add_wb", WB_R);          retire(); step();

    // lw with two wait cycles in FETCH and in MEM
    op = 6'b100100; mem_ready = 1'b0;
    chk_perf("perf_after_add");
    chk("lw_fetch_w1", F_WAIT);   step();
    chk("lw_fetch_w2", F_WAIT);   step();
    mem_ready = 1'b1;
    chk("lw_fetch_go", F_GO);     step();
    mem_ready = 1'b0;
    chk("lw_decode", DEC);        step();
    chk("lw_exec", EX_LS);        step();
    chk("lw_mem_w1", MEM_LW);     step();
    chk("lw_mem_w2", MEM_LW);     step();
    mem_ready = 1'b1;
    chk("lw_mem_go", MEM_LW);     step();
    mem_ready = 1'b0;
    chk("lw_wb", WB_LW);          retire(); step();

    // beq taken, beq not taken, bne taken, then j
    mem_ready = 1'b1; op = 6'b100000; zero = 1'b1;
    chk("beqT_fetch", F_GO);      step();
    chk("beqT_decode", DEC);      step();
    chk("beqT_exec", EX_BRT);     retire(); step();
    zero = 1'b0;
    chk("beqN_fetch", F_GO);      step();
    chk("beqN_decode", DEC);      step();
    chk("beqN_exec", EX_BRN);     retire(); step();
    op = 6'b100001;
    chk("bne_fetch", F_GO);       step();
    chk("bne_decode", DEC);       step();
    chk("bne_exec", EX_BRT);      retire(); step();
    op = 6'b100011;
    chk("j_fetch", F_GO);         step();
    chk("j_decode", DEC);         step();
    chk("j_exec", EX_J);          retire(); step();

    // andi then sw
    op = 6'b011000;
    chk("andi_fetch", F_GO);      step();
    chk("andi_decode", DEC);      step();
    chk("andi_exec", EX_ANDI);    step();
    chk("andi_wb", WB_I);         retire(); step();
    op = 6'b100101;
    chk("sw_fetch", F_GO);        step();
    chk("sw_decode", DEC);        step();
    chk("sw_exec", EX_LS);        step();
    chk("sw_mem", MEM_SW);        retire(); step();

    // illegal opcode traps; mem_ready is held high and must be ignored
    op = 6'b111000;
    chk("ill_fetch", F_GO);       step();
    chk_perf("perf_before_trap");
    chk("ill_decode", DEC);
`ifdef MC_CTRL_PERF_EN
    @(posedge clk); exp_cyc++; in_trap = 1'b1; #1;
`else
    step();
`endif
    for (int i = 0; i < 10; i++) begin
      chk("trap_hold", TRAP);     step();
    end
    chk_perf("perf_frozen_trap");

    rst_n = 1'b0;
    chk("trap_reset", ZERO);
    step();
`ifdef MC_CTRL_PERF_EN
    exp_cyc = 0; exp_ret = 0; in_trap = 1'b0;
`endif
    rst_n = 1'b1; op = 6'b000000; mem_ready = 1'b0;
    chk("post_trap_fetch", F_WAIT);
    chk_perf("perf_after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
